// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multicycle fetch/execute sequencer driving the PC unit
//
// Purpose:
//   Steps each instruction through FETCH (MEM_LAT cycles), DECODE and EXEC.
//   It also handles the IN handshake (WAIT_IN) and HALT/resume.
//   In EXEC it turns the decoded class flags into a PC unit select and a
//   register write strobe. Retired-instruction and input-wait counters are
//   kept for debug.
//
// Parameters:
//   MEM_LAT  instruction fetch latency in cycles, 1..15
//   CNT_W    width of the retired / wait counters
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous active-high reset
//   is_halt     decoded class HALT
//   is_in       decoded class IN (read input device)
//   is_jump     decoded class unconditional jump
//   is_branch   decoded class conditional branch
//   in_valid    input device has data (level)
//   resume      leave HALT
//   pc_sel      PC unit select: 1=+1 2=branch 3=jump 4=hold 5=advance on process_in
//   process_in  PC unit advance strobe for select 5
//   pc_rst_n    PC unit synchronous clear, active-low
//   ir_load     load instruction register
//   reg_write   register file write enable
//   in_ack      input consumed
//   halted      high while in HALT
//   err_multi   sticky: more than one class flag seen in EXEC
//   retired     instructions completed (wraps)
//   wait_cnt    cycles spent in WAIT_IN for the latest IN (saturates)

module pc_sequencer #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             is_halt,
  input  logic             is_in,
  input  logic             is_jump,
  input  logic             is_branch,
  input  logic             in_valid,
  input  logic             resume,
  output logic [3:0]       pc_sel,
  output logic             process_in,
  output logic             pc_rst_n,
  output logic             ir_load,
  output logic             reg_write,
  output logic             in_ack,
  output logic             halted,
  output logic             err_multi,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] wait_cnt
);

  typedef enum logic [2:0] {
    ST_RST_HOLD = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_EXEC     = 3'd3,
    ST_WAIT_IN  = 3'd4,
    ST_HALT     = 3'd5
  } state_t;

  localparam logic [3:0] SEL_INC     = 4'd1;
  localparam logic [3:0] SEL_BRANCH  = 4'd2;
  localparam logic [3:0] SEL_JUMP    = 4'd3;
  localparam logic [3:0] SEL_HOLD    = 4'd4;
  localparam logic [3:0] SEL_PROC_IN = 4'd5;

  localparam logic [3:0]       LP_FETCH_LAST = 4'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] LP_ONE        = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [3:0]       r_fetch_cnt;
  logic [CNT_W-1:0] r_retired;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_err_multi;

  logic             w_fetch_last;
  logic [2:0]       w_flag_sum;
  logic             w_multi;

  assign w_fetch_last = (r_fetch_cnt == LP_FETCH_LAST);
  assign w_flag_sum   = {2'b00, is_halt} + {2'b00, is_in} + {2'b00, is_jump} + {2'b00, is_branch};
  assign w_multi      = (w_flag_sum >= 3'd2);

  // State and counters. Reset holds the sequencer in RST_HOLD so the PC unit
  // sees its clear for exactly one edge after reset is released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RST_HOLD;
      r_fetch_cnt <= 4'd0;
      r_retired   <= '0;
      r_wait_cnt  <= '0;
      r_err_multi <= 1'b0;
    end else begin
      case (r_state)
        ST_RST_HOLD: begin
          r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (w_fetch_last) begin
            r_fetch_cnt <= 4'd0;
            r_state     <= ST_DECODE;
          end else begin
            r_fetch_cnt <= r_fetch_cnt + 4'd1;
          end
        end
        ST_DECODE: begin
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (w_multi) begin
            r_err_multi <= 1'b1;
          end
          if (is_halt) begin
            r_retired <= r_retired + LP_ONE;
            r_state   <= ST_HALT;
          end else if (is_in) begin
            // IN retires only once the input is consumed in WAIT_IN
            r_wait_cnt <= '0;
            r_state    <= ST_WAIT_IN;
          end else begin
            r_retired <= r_retired + LP_ONE;
            r_state   <= ST_FETCH;
          end
        end
        ST_WAIT_IN: begin
          if (in_valid) begin
            r_retired <= r_retired + LP_ONE;
            r_state   <= ST_FETCH;
          end else if (r_wait_cnt != {CNT_W{1'b1}}) begin
            r_wait_cnt <= r_wait_cnt + LP_ONE;
          end
        end
        ST_HALT: begin
          if (resume) begin
            r_state <= ST_FETCH;
          end
        end
        default: begin
          r_state <= ST_RST_HOLD;
        end
      endcase
    end
  end

  // Output decode from state plus the inputs sampled in EXEC / WAIT_IN / HALT.
  // Because it is combinational from state, strobes drop the moment the async
  // reset forces RST_HOLD.
  always_comb begin
    pc_sel     = SEL_HOLD;
    process_in = 1'b0;
    pc_rst_n   = 1'b1;
    ir_load    = 1'b0;
    reg_write  = 1'b0;
    in_ack     = 1'b0;
    halted     = 1'b0;
    case (r_state)
      ST_RST_HOLD: begin
        pc_rst_n = 1'b0;
      end
      ST_FETCH: begin
        ir_load = w_fetch_last;
      end
      ST_EXEC: begin
        if (is_halt || is_in) begin
          pc_sel = SEL_HOLD;
        end else if (is_jump) begin
          pc_sel = SEL_JUMP;
        end else if (is_branch) begin
          // the PC unit resolves the branch condition itself
          pc_sel = SEL_BRANCH;
        end else begin
          pc_sel    = SEL_INC;
          reg_write = 1'b1;
        end
      end
      ST_WAIT_IN: begin
        pc_sel     = SEL_PROC_IN;
        process_in = in_valid;
        in_ack     = in_valid;
        reg_write  = in_valid;
      end
      ST_HALT: begin
        halted = 1'b1;
        if (resume) begin
          pc_sel = SEL_INC;
        end
      end
      default: begin
        pc_sel = SEL_HOLD;
      end
    endcase
  end

  assign retired   = r_retired;
  assign wait_cnt  = r_wait_cnt;
  assign err_multi = r_err_multi;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer (MEM_LAT 1 and 3)

module tb_pc_sequencer;

  localparam int CNT_W = 32;

  logic clock = 1'b0;
  logic rst1, rst3;
  logic is_halt, is_in, is_jump, is_branch, in_valid, resume;

  logic [3:0]       d1_pc_sel, d3_pc_sel;
  logic             d1_process_in, d1_pc_rst_n, d1_ir_load, d1_reg_write, d1_in_ack, d1_halted, d1_err_multi;
  logic             d3_process_in, d3_pc_rst_n, d3_ir_load, d3_reg_write, d3_in_ack, d3_halted, d3_err_multi;
  logic [CNT_W-1:0] d1_retired, d1_wait_cnt, d3_retired, d3_wait_cnt;

  pc_sequencer #(.MEM_LAT(1), .CNT_W(CNT_W)) u_dut1 (
    .clock(clock), .reset(rst1),
    .is_halt(is_halt), .is_in(is_in), .is_jump(is_jump), .is_branch(is_branch),
    .in_valid(in_valid), .resume(resume),
    .pc_sel(d1_pc_sel), .process_in(d1_process_in), .pc_rst_n(d1_pc_rst_n),
    .ir_load(d1_ir_load), .reg_write(d1_reg_write), .in_ack(d1_in_ack),
    .halted(d1_halted), .err_multi(d1_err_multi),
    .retired(d1_retired), .wait_cnt(d1_wait_cnt)
  );

  pc_sequencer #(.MEM_LAT(3), .CNT_W(CNT_W)) u_dut3 (
    .clock(clock), .reset(rst3),
    .is_halt(is_halt), .is_in(is_in), .is_jump(is_jump), .is_branch(is_branch),
    .in_valid(in_valid), .resume(resume),
    .pc_sel(d3_pc_sel), .process_in(d3_process_in), .pc_rst_n(d3_pc_rst_n),
    .ir_load(d3_ir_load), .reg_write(d3_reg_write), .in_ack(d3_in_ack),
    .halted(d3_halted), .err_multi(d3_err_multi),
    .retired(d3_retired), .wait_cnt(d3_wait_cnt)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] sel;
    logic       ir;
    logic       rw;
    logic       ack;
    logic       pin;
    string      tag;
  } ev_t;

  ev_t q1[$];
  ev_t q3[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_ev(input string who, input ev_t e, input int c, input logic [3:0] sel,
                        input logic ir, input logic rw, input logic ack, input logic pin);
    n_checks++;
    if (e.cyc != c || e.sel !== sel || e.ir !== ir || e.rw !== rw || e.ack !== ack || e.pin !== pin) begin
      n_fail++;
      $display("FAIL %s %s: got cyc=%0d sel=%0d ir=%b rw=%b ack=%b pin=%b expected cyc=%0d sel=%0d ir=%b rw=%b ack=%b pin=%b",
               who, e.tag, c, sel, ir, rw, ack, pin, e.cyc, e.sel, e.ir, e.rw, e.ack, e.pin);
    end
  endtask

  // Monitors: any strobe or a non-hold select is a DUT output event
  always @(negedge clock) begin
    if (d1_ir_load || d1_reg_write || d1_in_ack || d1_process_in || d1_pc_sel != 4'd4) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut1 unexpected event: got cyc=%0d sel=%0d expected none", cyc, d1_pc_sel);
      end else begin
        cmp_ev("dut1", q1.pop_front(), cyc, d1_pc_sel, d1_ir_load, d1_reg_write, d1_in_ack, d1_process_in);
      end
    end
  end

  always @(negedge clock) begin
    if (d3_ir_load || d3_reg_write || d3_in_ack || d3_process_in || d3_pc_sel != 4'd4) begin
      if (q3.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut3 unexpected event: got cyc=%0d sel=%0d expected none", cyc, d3_pc_sel);
      end else begin
        cmp_ev("dut3", q3.pop_front(), cyc, d3_pc_sel, d3_ir_load, d3_reg_write, d3_in_ack, d3_process_in);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push3(input int c, input logic [3:0] sel, input logic ir, input logic rw,
                       input logic ack, input logic pin, input string tag);
    ev_t e;
    e.cyc = c; e.sel = sel; e.ir = ir; e.rw = rw; e.ack = ack; e.pin = pin; e.tag = tag;
    q3.push_back(e);
  endtask

  // Entered at #1 into the first FETCH cycle of a non-IN, non-HALT instruction.
  // MEM_LAT=3: ir_load at +2, EXEC at +4, next FETCH at +5.
  task automatic run_instr(input string tag, input logic j, input logic b,
                           input logic [3:0] exp_sel, input logic exp_rw);
    int c;
    c = cyc;
    is_jump = j; is_branch = b;
    push3(c + 2, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, {tag, "_ir"});
    push3(c + 4, exp_sel, 1'b0, exp_rw, 1'b0, 1'b0, {tag, "_exec"});
    repeat (5) tick();
    is_jump = 1'b0; is_branch = 1'b0;
  endtask

  int c;
  int exp_ret;
  ev_t e1;

  initial begin
    rst1 = 1'b1; rst3 = 1'b1;
    is_halt = 0; is_in = 0; is_jump = 0; is_branch = 0; in_valid = 0; resume = 0;
    repeat (3) tick();

    // MEM_LAT=1, ALU instruction
    chk("d1_reset_pc_rst_n", d1_pc_rst_n, 0);
    chk("d1_reset_pc_sel", d1_pc_sel, 4);
    chk("d1_reset_retired", d1_retired, 0);
    rst1 = 1'b0;
    c = cyc;
    e1.cyc = c + 1; e1.sel = 4; e1.ir = 1; e1.rw = 0; e1.ack = 0; e1.pin = 0; e1.tag = "d1_ir";
    q1.push_back(e1);
    e1.cyc = c + 3; e1.sel = 1; e1.ir = 0; e1.rw = 1; e1.tag = "d1_alu_exec";
    q1.push_back(e1);
    #1 chk("d1_rst_hold_pc_rst_n", d1_pc_rst_n, 0);
    tick();
    chk("d1_fetch_pc_rst_n", d1_pc_rst_n, 1);
    repeat (3) tick();
    chk("d1_retired_after_alu", d1_retired, 1);
    rst1 = 1'b1;
    #1;

    // MEM_LAT=3 main sequence
    rst3 = 1'b0;
    #1;
    chk("d3_rst_hold_pc_rst_n", d3_pc_rst_n, 0);
    chk("d3_reset_pc_sel", d3_pc_sel, 4);
    chk("d3_reset_halted", d3_halted, 0);
    chk("d3_reset_err", d3_err_multi, 0);
    chk("d3_reset_retired", d3_retired, 0);
    chk("d3_reset_wait", d3_wait_cnt, 0);
    tick();
    chk("d3_fetch_pc_rst_n", d3_pc_rst_n, 1);
    exp_ret = 0;

    run_instr("jump", 1'b1, 1'b0, 4'd3, 1'b0);
    exp_ret++; chk("retired_jump", d3_retired, exp_ret);
    run_instr("branch", 1'b0, 1'b1, 4'd2, 1'b0);
    exp_ret++; chk("retired_branch", d3_retired, exp_ret);
    run_instr("alu", 1'b0, 1'b0, 4'd1, 1'b1);
    exp_ret++; chk("retired_alu", d3_retired, exp_ret);
    chk("err_clean", d3_err_multi, 0);

    // IN: 7 idle WAIT_IN cycles then data
    c = cyc;
    is_in = 1'b1;
    push3(c + 2, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, "in_ir");
    for (int k = 0; k < 7; k++) push3(c + 5 + k, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, "in_wait");
    push3(c + 12, 4'd5, 1'b0, 1'b1, 1'b1, 1'b1, "in_take");
    repeat (5) tick();
    is_in = 1'b0;
    chk("in_wait_cnt_start", d3_wait_cnt, 0);
    chk("in_not_retired_yet", d3_retired, exp_ret);
    repeat (7) tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_ret++; chk("retired_in", d3_retired, exp_ret);
    chk("in_wait_cnt", d3_wait_cnt, 7);

    // HALT for 10 cycles then resume
    c = cyc;
    is_halt = 1'b1;
    push3(c + 2, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, "halt_ir");
    repeat (5) tick();
    is_halt = 1'b0;
    exp_ret++; chk("retired_halt", d3_retired, exp_ret);
    chk("halted_entry", d3_halted, 1);
    repeat (9) tick();
    chk("halted_still", d3_halted, 1);
    chk("halt_pc_sel", d3_pc_sel, 4);
    tick();
    resume = 1'b1;
    push3(c + 15, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, "resume");
    tick();
    resume = 1'b0;
    chk("halted_after_resume", d3_halted, 0);
    chk("wait_cnt_held", d3_wait_cnt, 7);

    // jump and branch together: jump wins, sticky error
    run_instr("jmp_br", 1'b1, 1'b1, 4'd3, 1'b0);
    exp_ret++; chk("retired_multi", d3_retired, exp_ret);
    chk("err_multi_set", d3_err_multi, 1);
    run_instr("alu2", 1'b0, 1'b0, 4'd1, 1'b1);
    exp_ret++; chk("retired_alu2", d3_retired, exp_ret);
    chk("err_multi_sticky", d3_err_multi, 1);

    // IN interrupted by reset while in_valid is high
    c = cyc;
    is_in = 1'b1;
    push3(c + 2, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, "in2_ir");
    push3(c + 5, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, "in2_wait");
    push3(c + 6, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, "in2_wait");
    repeat (5) tick();
    is_in = 1'b0;
    chk("in2_wait_cnt_cleared", d3_wait_cnt, 0);
    repeat (2) tick();
    in_valid = 1'b1;
    #1;
    chk("in2_ack_before_reset", d3_in_ack, 1);
    chk("in2_pin_before_reset", d3_process_in, 1);
    rst3 = 1'b1;
    #1;
    chk("rst_in_ack", d3_in_ack, 0);
    chk("rst_process_in", d3_process_in, 0);
    chk("rst_reg_write", d3_reg_write, 0);
    chk("rst_pc_sel", d3_pc_sel, 4);
    chk("rst_pc_rst_n", d3_pc_rst_n, 0);
    chk("rst_retired", d3_retired, 0);
    chk("rst_wait_cnt", d3_wait_cnt, 0);
    chk("rst_err_multi", d3_err_multi, 0);
    in_valid = 1'b0;
    repeat (2) tick();
    rst3 = 1'b0;
    #1;
    chk("rel_rst_hold", d3_pc_rst_n, 0);
    tick();
    chk("rel_fetch", d3_pc_rst_n, 1);
    run_instr("alu3", 1'b0, 1'b0, 4'd1, 1'b1);
    chk("retired_after_rerst", d3_retired, 1);
    rst3 = 1'b1;
    repeat (3) tick();

    chk("q1_drained", q1.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
